// File: rtl/bram_selftest_if.sv
// Control/status bundle for the BRAM self-test. Macro BRAM_SELFTEST_FAULT_INJECT_EN adds the inject input.
// Handshake: start is accepted on a rising sys_clk edge only while busy=0 (IDLE or DONE); done then holds until the next accepted start.
interface bram_selftest_if #(
    parameter int ADDRESS_BITWIDTH = 10
);
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        pass;
    logic [ADDRESS_BITWIDTH:0]   error_count;
    logic [ADDRESS_BITWIDTH-1:0] fail_address;
    logic [5:0]                  led;
    logic [2:0]                  state_dbg;
`ifdef BRAM_SELFTEST_FAULT_INJECT_EN
    logic                        inject;

    modport master (output start, output inject,
                    input busy, input done, input pass, input error_count,
                    input fail_address, input led, input state_dbg);
    modport slave  (input start, input inject,
                    output busy, output done, output pass, output error_count,
                    output fail_address, output led, output state_dbg);
`else
    modport master (output start,
                    input busy, input done, input pass, input error_count,
                    input fail_address, input led, input state_dbg);
    modport slave  (input start,
                    output busy, output done, output pass, output error_count,
                    output fail_address, output led, output state_dbg);
`endif
endinterface

// File: rtl/bram_selftest.sv
// Built-in self-test of a byte-enabled dual-port RAM: clear, per-lane pattern write, pipelined read-back check.
// Optional macro BRAM_SELFTEST_FAULT_INJECT_EN flips bit 0 of the expected word at address 1 when inject is set at start.
module bram_selftest #(
    parameter int          ADDRESS_BITWIDTH = 10,
    parameter int          DATA_BITWIDTH    = 32,
    parameter int          COLUMN_BITWIDTH  = 8,
    parameter logic [31:0] PATTERN          = 32'habcd_ef12
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    bram_selftest_if.slave bus
);
    localparam int          AW      = ADDRESS_BITWIDTH;
    localparam int          DW      = DATA_BITWIDTH;
    localparam int          CW      = COLUMN_BITWIDTH;
    localparam int unsigned COLUMNS = DW / CW;
    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [DW-1:0] PAT       = DW'(PATTERN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LANE  = 3'd2,
        CHECK = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state, next_state;
    logic [AW-1:0]        addr;
    logic [AW-1:0]        a_address, b_address;
    logic [COLUMNS-1:0]   a_we;
    logic [DW-1:0]        a_data_in, b_data_out;
    logic [DW-1:0]        expected;
    logic                 accept;
    logic                 rd_valid;
    logic [AW-1:0]        rd_addr;
    logic [AW:0]          error_count;
    logic [AW-1:0]        fail_address;
    logic                 busy, done, pass;
    logic [DW-1:0]        ram [DEPTH];
`ifdef BRAM_SELFTEST_FAULT_INJECT_EN
    logic                 inject_q;
`endif

    function automatic int unsigned lane_of(input logic [AW-1:0] a);
        return 32'(a) % COLUMNS;
    endfunction

    // Only lane (a mod COLUMNS) carries data; it is the pattern column XOR the low address bits.
    function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
        logic [DW-1:0]    w;
        logic [AW+CW-1:0] a_ext;
        int unsigned      lane;
        a_ext = {{CW{1'b0}}, a};
        lane  = lane_of(a);
        w     = '0;
        for (int unsigned k = 0; k < COLUMNS; k++) begin
            if (k == lane) w[k*CW +: CW] = PAT[k*CW +: CW] ^ a_ext[CW-1:0];
        end
        return w;
    endfunction

    assign a_address = addr;
    assign b_address = addr;

    always_ff @(posedge sys_clk) begin
        for (int unsigned c = 0; c < COLUMNS; c++) begin
            if (a_we[c]) ram[a_address][c*CW +: CW] <= a_data_in[c*CW +: CW];
        end
        b_data_out <= ram[b_address];
    end

`ifdef BRAM_SELFTEST_FAULT_INJECT_EN
    assign expected = exp_word(rd_addr) ^ {{(DW-1){1'b0}}, (inject_q && rd_addr == AW'(1))};
`else
    assign expected = exp_word(rd_addr);
`endif

    always_comb begin
        next_state = state;
        a_we       = '0;
        a_data_in  = '0;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    next_state = CLEAR;
                    accept     = 1'b1;
                end
            end
            CLEAR: begin
                a_we = '1;
                if (addr == LAST_ADDR) next_state = LANE;
            end
            LANE: begin
                a_we      = COLUMNS'(1) << lane_of(addr);
                a_data_in = exp_word(addr);
                if (addr == LAST_ADDR) next_state = CHECK;
            end
            CHECK: begin
                if (addr == LAST_ADDR) next_state = DRAIN;
            end
            DRAIN:   next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            rd_valid     <= 1'b0;
            rd_addr      <= '0;
            error_count  <= '0;
            fail_address <= '0;
`ifdef BRAM_SELFTEST_FAULT_INJECT_EN
            inject_q     <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (accept) begin
                addr         <= '0;
                rd_valid     <= 1'b0;
                error_count  <= '0;
                fail_address <= '0;
`ifdef BRAM_SELFTEST_FAULT_INJECT_EN
                inject_q     <= bus.inject;
`endif
            end else begin
                // Wrap back to 0 doubles as the start address of the next phase.
                if (state == CLEAR || state == LANE || state == CHECK) addr <= addr + 1'b1;
                rd_valid <= (state == CHECK);
                rd_addr  <= addr;
                if (rd_valid && (b_data_out != expected)) begin
                    error_count <= error_count + 1'b1;
                    if (error_count == '0) fail_address <= rd_addr;
                end
            end
        end
    end

    assign busy = (state == CLEAR) || (state == LANE) || (state == CHECK) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (error_count == '0);

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.pass         = pass;
    assign bus.error_count  = error_count;
    assign bus.fail_address = fail_address;
    assign bus.led          = ~{error_count[2:0], pass, done, busy};
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_bram_selftest.sv
// Bench for bram_selftest: default-size instance checked through a done-driven scoreboard, small instance for RAM contents.
module tb_bram_selftest;
    localparam int DEPTH = 1024;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    bram_selftest_if #(.ADDRESS_BITWIDTH(10)) bus   ();
    bram_selftest_if #(.ADDRESS_BITWIDTH(3))  bus_s ();

    bram_selftest #(.ADDRESS_BITWIDTH(10)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    bram_selftest #(.ADDRESS_BITWIDTH(3)) dut_s (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_s)
    );

    int checks      = 0;
    int errors      = 0;
    int edge_cnt    = 0;
    int accept_edge = 0;
    logic done_q    = 1'b0;
    // {done_cycle[15:0], pass, error_count[10:0], fail_address[9:0], led[5:0]}
    logic [43:0] exp_q[$];

    always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every rising done on the main instance consumes one expected result.
    always @(negedge sys_clk) begin
        logic [43:0] e;
        if (bus.done && !done_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                check("done_cycle",   32'(edge_cnt - accept_edge + 1), 32'(e[43:28]));
                check("pass",         32'(bus.pass),                   32'(e[27]));
                check("error_count",  32'(bus.error_count),            32'(e[26:16]));
                check("fail_address", 32'(bus.fail_address),           32'(e[15:6]));
                check("led",          32'(bus.led),                    32'(e[5:0]));
            end
        end
        done_q = bus.done;
    end

    task automatic run_main(input logic inj, input logic exp_pass, input int exp_ec,
                            input int exp_fa, input bit mid_pulses);
        logic [2:0] ec3;
        logic [5:0] led_e;
        int n;
        bit seen;
        @(negedge sys_clk);
        bus.start = 1'b1;
`ifdef BRAM_SELFTEST_FAULT_INJECT_EN
        bus.inject = inj;
`else
        if (inj) $display("note: inject requested but not built in");
`endif
        @(posedge sys_clk);
        #1;
        accept_edge = edge_cnt;
        bus.start = 1'b0;
        ec3   = exp_ec[2:0];
        led_e = ~{ec3, exp_pass, 1'b1, 1'b0};
        exp_q.push_back({16'(3 * DEPTH + 2), exp_pass, 11'(exp_ec), 10'(exp_fa), led_e});
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("done_after_start", 32'(bus.done), 32'd0);
        n = 1;
        seen = 1'b0;
        while (!seen && n < 4000) begin
            bus.start = (mid_pulses && (n == 10 || n == 500)) ? 1'b1 : 1'b0;
            @(posedge sys_clk);
            #1;
            n++;
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d required=%0d", n, 3 * DEPTH + 2);
            exp_q.delete();
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
    endtask

    initial begin
        int n;
        bus.start   = 1'b0;
        bus_s.start = 1'b0;
`ifdef BRAM_SELFTEST_FAULT_INJECT_EN
        bus.inject   = 1'b0;
        bus_s.inject = 1'b0;
`endif
        repeat (3) @(negedge sys_clk);
        check("rst_busy",         32'(bus.busy),         32'd0);
        check("rst_done",         32'(bus.done),         32'd0);
        check("rst_pass",         32'(bus.pass),         32'd0);
        check("rst_error_count",  32'(bus.error_count),  32'd0);
        check("rst_fail_address", 32'(bus.fail_address), 32'd0);
        check("rst_led",          32'(bus.led),          32'h3f);
        sys_rst_n = 1'b1;

        // Small RAM: 8 words, done at cycle 26, then inspect stored lanes.
        @(negedge sys_clk);
        bus_s.start = 1'b1;
        @(posedge sys_clk);
        #1;
        bus_s.start = 1'b0;
        n = 1;
        while (!bus_s.done && n < 100) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        check("small_done_cycle",  32'(n),                   32'd26);
        check("small_pass",        32'(bus_s.pass),          32'd1);
        check("small_error_count", 32'(bus_s.error_count),   32'd0);
        check("small_word5",       dut_s.ram[5],             32'h0000_ea00);
        check("small_word4",       dut_s.ram[4],             32'h0000_0016);
        check("small_word3",       dut_s.ram[3],             32'ha800_0000);
        check("small_word2",       dut_s.ram[2],             32'h00cf_0000);
        check("small_word0",       dut_s.ram[0],             32'h0000_0012);
        check("small_word7",       dut_s.ram[7],             32'hac00_0000);

        // Plain run, then a run with ignored mid-run start pulses.
        run_main(1'b0, 1'b1, 0, 0, 1'b0);
        run_main(1'b0, 1'b1, 0, 0, 1'b1);

        // Asynchronous reset during CHECK.
        @(negedge sys_clk);
        bus.start = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.state_dbg != 3'd3 && n < 3000) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        check("reached_check", 32'(bus.state_dbg), 32'd3);
        repeat (100) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_busy",        32'(bus.busy),        32'd0);
        check("midrst_done",        32'(bus.done),        32'd0);
        check("midrst_led",         32'(bus.led),         32'h3f);
        check("midrst_error_count", 32'(bus.error_count), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run_main(1'b0, 1'b1, 0, 0, 1'b0);

`ifdef BRAM_SELFTEST_FAULT_INJECT_EN
        run_main(1'b1, 1'b0, 1, 1, 1'b0);
        run_main(1'b0, 1'b1, 0, 0, 1'b0);
`endif

        @(negedge sys_clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
